// File: rtl/vv_add_stream_core.sv
// rtl/vv_add_stream_core.sv - sequenced, back-pressured lane-wise vector adder with index/bank-select tagging
module vv_add_stream_core #(
    parameter int DW    = 32,
    parameter int LANES = 4,
    parameter int LEN_W = 7,
    parameter int SEL_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [LEN_W-1:0]        len,
    input  logic                    sat,
    input  logic                    a_vld,
    output logic                    a_rdy,
    input  logic [LANES*DW-1:0]     a_data,
    input  logic                    b_vld,
    output logic                    b_rdy,
    input  logic [LANES*DW-1:0]     b_data,
    output logic                    o_vld,
    input  logic                    o_rdy,
    output logic [LANES*DW-1:0]     o_data,
    output logic [LEN_W-1:0]        o_idx,
    output logic [(1<<SEL_W)-1:0]   o_sel,
    output logic                    o_last,
    output logic                    busy,
    output logic                    done
);
    localparam int SEL_N = 1 << SEL_W;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t              state;
    logic [LEN_W-1:0]    cnt;
    logic [LEN_W-1:0]    len_q;
    logic                sat_q;
    logic                accept;
    logic                last_beat;
    logic [LANES*DW-1:0] sum_data;
    logic [SEL_N-1:0]    sel_dec;

    // Both operands move together, and only when the output register can take the result.
    assign accept    = (state == RUN) & a_vld & b_vld & (~o_vld | o_rdy);
    assign a_rdy     = accept;
    assign b_rdy     = accept;
    assign busy      = (state != IDLE);
    assign last_beat = (cnt == len_q - LEN_W'(1));
    assign sel_dec   = SEL_N'(1) << cnt[SEL_W-1:0];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [DW:0] s;
        assign s = {1'b0, a_data[g*DW +: DW]} + {1'b0, b_data[g*DW +: DW]};
        assign sum_data[g*DW +: DW] = (sat_q & s[DW]) ? {DW{1'b1}} : s[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            len_q  <= '0;
            sat_q  <= 1'b0;
            o_vld  <= 1'b0;
            o_data <= '0;
            o_idx  <= '0;
            o_sel  <= '0;
            o_last <= 1'b0;
            done   <= 1'b0;
        end else begin
            if (accept) begin
                o_vld  <= 1'b1;
                o_data <= sum_data;
                o_idx  <= cnt;
                o_sel  <= sel_dec;
                o_last <= last_beat;
                cnt    <= cnt + LEN_W'(1);
            end else if (o_rdy) begin
                o_vld  <= 1'b0;
            end

            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q <= len;
                        sat_q <= sat;
                        cnt   <= '0;
                        state <= (len != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (accept && last_beat)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (o_vld && o_rdy && o_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // A zero-length command arrives here with done low and spends one extra cycle raising it.
                    if (done) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end else begin
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vv_add_stream_core.sv
// tb/tb_vv_add_stream_core.sv - directed self-checking bench for vv_add_stream_core
module tb_vv_add_stream_core;
    localparam int DW = 32, LANES = 4, LEN_W = 7, SEL_W = 4;
    localparam int BW = LANES * DW, SN = 1 << SEL_W;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0, sat = 1'b0;
    logic a_vld = 1'b0, b_vld = 1'b0, o_rdy = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic [BW-1:0] a_data = '0, b_data = '0;
    logic a_rdy, b_rdy, o_vld, o_last, busy, done;
    logic [BW-1:0] o_data;
    logic [LEN_W-1:0] o_idx;
    logic [SN-1:0] o_sel;

    vv_add_stream_core #(.DW(DW), .LANES(LANES), .LEN_W(LEN_W), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .sat(sat),
        .a_vld(a_vld), .a_rdy(a_rdy), .a_data(a_data),
        .b_vld(b_vld), .b_rdy(b_rdy), .b_data(b_data),
        .o_vld(o_vld), .o_rdy(o_rdy), .o_data(o_data), .o_idx(o_idx),
        .o_sel(o_sel), .o_last(o_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    logic [BW-1:0]    rec_data [64];
    logic [LEN_W-1:0] rec_idx  [64];
    logic [SN-1:0]    rec_sel  [64];
    logic             rec_last [64];
    int   nrec, done_at, first_vld;
    logic busy_at0, after_done, after_busy;
    bit   stall_a_rdy, stall_changed;

    function automatic logic [31:0] av(int k, int i);
        case (i)
            0: return (k == 0) ? 32'hFFFF_FFFF : 32'(k * 3);
            1: return 32'd5;
            2: return 32'h0100_0000 + 32'(k);
            default: return 32'hF000_0000 + 32'(k);
        endcase
    endfunction

    function automatic logic [31:0] bv(int k, int i);
        case (i)
            0: return (k == 0) ? 32'd2 : 32'h10;
            1: return 32'd7;
            2: return 32'(k);
            default: return 32'h2000_0000;
        endcase
    endfunction

    function automatic logic [BW-1:0] pack_a(int k);
        logic [BW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = av(k, i);
        return r;
    endfunction

    function automatic logic [BW-1:0] pack_b(int k);
        logic [BW-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*DW +: DW] = bv(k, i);
        return r;
    endfunction

    function automatic logic [BW-1:0] exp_beat(int k, bit s);
        logic [BW-1:0] r;
        logic [32:0] t;
        for (int i = 0; i < LANES; i++) begin
            t = {1'b0, av(k, i)} + {1'b0, bv(k, i)};
            r[i*DW +: DW] = (s && t[32]) ? 32'hFFFF_FFFF : t[31:0];
        end
        return r;
    endfunction

    function automatic logic [SN-1:0] exp_sel(int k);
        logic [SN-1:0] e;
        e = 1;
        return e << (k % SN);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one command and records every popped output beat plus timing markers.
    task automatic run_cmd(input int n_len, input bit n_sat, input int stall_idx, input int stall_n, input int mid_at);
        int ecount, sent, scnt;
        bit acc;
        logic [BW+LEN_W+SN:0] snap;
        start = 1'b1; len = LEN_W'(n_len); sat = n_sat;
        step();
        start = 1'b0;
        busy_at0 = busy;
        ecount = 0; sent = 0; scnt = 0; nrec = 0; done_at = -1; first_vld = -1;
        stall_a_rdy = 0; stall_changed = 0; snap = '0;
        while (done_at < 0 && ecount < 300) begin
            a_vld = (sent < n_len); b_vld = (sent < n_len);
            a_data = pack_a(sent); b_data = pack_b(sent);
            start = (ecount == mid_at);
            len = (ecount == mid_at) ? LEN_W'(3) : LEN_W'(n_len);
            if (stall_n > 0 && o_vld && int'(o_idx) == stall_idx && scnt < stall_n) begin
                o_rdy = 1'b0;
                if (scnt == 0) snap = {o_data, o_idx, o_sel, o_last};
                else if (snap !== {o_data, o_idx, o_sel, o_last}) stall_changed = 1;
                scnt++;
                #1;
                if (a_rdy || b_rdy) stall_a_rdy = 1;
            end else begin
                o_rdy = 1'b1;
                #1;
            end
            acc = a_rdy && b_rdy;
            if (o_vld && first_vld < 0) first_vld = ecount;
            if (o_vld && o_rdy && nrec < 64) begin
                rec_data[nrec] = o_data; rec_idx[nrec] = o_idx;
                rec_sel[nrec] = o_sel; rec_last[nrec] = o_last;
                nrec++;
            end
            step();
            ecount++;
            if (acc) sent++;
            if (done) done_at = ecount;
        end
        start = 1'b0; a_vld = 1'b0; b_vld = 1'b0;
        step();
        after_done = done; after_busy = busy;
    endtask

    task automatic test_reset();
        checks++;
        if ({o_vld, o_data, o_idx, o_sel, o_last, a_rdy, b_rdy, busy, done} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got vld=%b idx=%0d sel=%h last=%b busy=%b done=%b exp all zero",
                     o_vld, o_idx, o_sel, o_last, busy, done);
        end
    endtask

    task automatic test_wrap();
        run_cmd(3, 0, -1, 0, -1);
        checks++; if (busy_at0 !== 1'b1) begin failures++; $display("FAIL wrap_busy got=%b exp=1", busy_at0); end
        checks++; if (nrec !== 3) begin failures++; $display("FAIL wrap_count got=%0d exp=3", nrec); end
        checks++; if (rec_data[0][31:0] !== 32'h0000_0001) begin failures++; $display("FAIL wrap_lane0 got=%h exp=00000001", rec_data[0][31:0]); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rec_data[k] !== exp_beat(k, 0) || rec_idx[k] !== LEN_W'(k) || rec_sel[k] !== exp_sel(k) || rec_last[k] !== (k == 2)) begin
                failures++;
                $display("FAIL wrap_beat%0d got data=%h idx=%0d sel=%h last=%b exp data=%h idx=%0d sel=%h last=%b",
                         k, rec_data[k], rec_idx[k], rec_sel[k], rec_last[k], exp_beat(k, 0), k, exp_sel(k), k == 2);
            end
        end
        checks++; if (first_vld !== 1) begin failures++; $display("FAIL wrap_latency got=%0d exp=1", first_vld); end
        checks++; if (done_at !== 4) begin failures++; $display("FAIL wrap_done_at got=%0d exp=4", done_at); end
        checks++; if (after_done !== 1'b0 || after_busy !== 1'b0) begin failures++; $display("FAIL wrap_idle got done=%b busy=%b exp 0 0", after_done, after_busy); end
    endtask

    task automatic test_saturate();
        run_cmd(3, 1, -1, 0, -1);
        checks++; if (rec_data[0][31:0] !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sat_lane0 got=%h exp=ffffffff", rec_data[0][31:0]); end
        checks++; if (rec_data[0][63:32] !== 32'd12) begin failures++; $display("FAIL sat_lane1 got=%0d exp=12", rec_data[0][63:32]); end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (rec_data[k] !== exp_beat(k, 1)) begin failures++; $display("FAIL sat_beat%0d got=%h exp=%h", k, rec_data[k], exp_beat(k, 1)); end
        end
        checks++; if (done_at !== 4) begin failures++; $display("FAIL sat_done_at got=%0d exp=4", done_at); end
    endtask

    task automatic test_back_pressure();
        run_cmd(4, 0, 1, 3, -1);
        checks++; if (nrec !== 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", nrec); end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rec_idx[k] !== LEN_W'(k) || rec_data[k] !== exp_beat(k, 0)) begin
                failures++; $display("FAIL bp_beat%0d got idx=%0d data=%h exp idx=%0d data=%h", k, rec_idx[k], rec_data[k], k, exp_beat(k, 0));
            end
        end
        checks++; if (rec_sel[1] !== 16'h0002) begin failures++; $display("FAIL bp_sel got=%h exp=0002", rec_sel[1]); end
        checks++; if (stall_changed !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_changed); end
        checks++; if (stall_a_rdy !== 0) begin failures++; $display("FAIL bp_rdy got=%0d exp=0", stall_a_rdy); end
        checks++; if (done_at !== 8) begin failures++; $display("FAIL bp_done_at got=%0d exp=8", done_at); end
    endtask

    task automatic test_join_stall();
        start = 1'b1; len = LEN_W'(1); sat = 1'b0;
        step();
        start = 1'b0;
        a_data = pack_a(0); b_data = pack_b(0); o_rdy = 1'b1;
        for (int c = 0; c < 5; c++) begin
            a_vld = 1'b1; b_vld = 1'b0;
            #1;
            checks++;
            if (a_rdy !== 1'b0 || b_rdy !== 1'b0 || o_vld !== 1'b0) begin
                failures++; $display("FAIL join_stall%0d got a_rdy=%b b_rdy=%b o_vld=%b exp 0 0 0", c, a_rdy, b_rdy, o_vld);
            end
            step();
        end
        b_vld = 1'b1;
        #1;
        checks++; if (a_rdy !== 1'b1 || b_rdy !== 1'b1) begin failures++; $display("FAIL join_accept got a_rdy=%b b_rdy=%b exp 1 1", a_rdy, b_rdy); end
        step();
        checks++;
        if (o_vld !== 1'b1 || o_data !== exp_beat(0, 0) || o_last !== 1'b1) begin
            failures++; $display("FAIL join_out got vld=%b data=%h last=%b exp vld=1 data=%h last=1", o_vld, o_data, o_last, exp_beat(0, 0));
        end
        #1;
        checks++; if (a_rdy !== 1'b0) begin failures++; $display("FAIL join_single got a_rdy=%b exp=0", a_rdy); end
        a_vld = 1'b0; b_vld = 1'b0;
        step();
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL join_done got=%b exp=1", done); end
        step();
    endtask

    task automatic test_index_wrap();
        int nlast;
        run_cmd(20, 0, -1, 0, 5);
        checks++; if (nrec !== 20) begin failures++; $display("FAIL wrap20_count got=%0d exp=20", nrec); end
        checks++; if (rec_sel[15] !== 16'h8000) begin failures++; $display("FAIL sel_idx15 got=%h exp=8000", rec_sel[15]); end
        checks++; if (rec_sel[16] !== 16'h0001) begin failures++; $display("FAIL sel_idx16 got=%h exp=0001", rec_sel[16]); end
        nlast = 0;
        for (int k = 0; k < 20; k++) if (rec_last[k] === 1'b1) nlast++;
        checks++; if (nlast !== 1 || rec_last[19] !== 1'b1) begin failures++; $display("FAIL last_idx19 got count=%0d last19=%b exp 1 1", nlast, rec_last[19]); end
        checks++; if (done_at !== 21) begin failures++; $display("FAIL wrap20_done_at got=%0d exp=21", done_at); end
    endtask

    task automatic test_zero_len();
        run_cmd(0, 0, -1, 0, -1);
        checks++; if (done_at !== 1) begin failures++; $display("FAIL zero_done_at got=%0d exp=1", done_at); end
        checks++; if (first_vld !== -1 || nrec !== 0) begin failures++; $display("FAIL zero_no_vld got first=%0d n=%0d exp -1 0", first_vld, nrec); end
        checks++; if (after_done !== 1'b0 || after_busy !== 1'b0) begin failures++; $display("FAIL zero_idle got done=%b busy=%b exp 0 0", after_done, after_busy); end
    endtask

    task automatic test_mid_reset();
        start = 1'b1; len = LEN_W'(5); sat = 1'b0;
        step();
        start = 1'b0;
        a_vld = 1'b1; b_vld = 1'b1; a_data = pack_a(0); b_data = pack_b(0); o_rdy = 1'b0;
        step();
        rst = 1'b1;
        step();
        #1;
        checks++;
        if ({o_vld, o_data, o_idx, o_sel, o_last, a_rdy, b_rdy, busy, done} !== '0) begin
            failures++;
            $display("FAIL mid_reset got vld=%b idx=%0d sel=%h last=%b rdy=%b busy=%b done=%b exp all zero",
                     o_vld, o_idx, o_sel, o_last, a_rdy, busy, done);
        end
        rst = 1'b0; a_vld = 1'b0; b_vld = 1'b0; o_rdy = 1'b1;
        step();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_reset_nodone got done=%b busy=%b exp 0 0", done, busy); end
        run_cmd(2, 0, -1, 0, -1);
        checks++;
        if (nrec !== 2 || rec_data[1] !== exp_beat(1, 0) || rec_last[1] !== 1'b1 || done_at !== 3) begin
            failures++; $display("FAIL fresh_start got n=%0d data1=%h last1=%b done_at=%0d exp n=2 data1=%h last1=1 done_at=3",
                                 nrec, rec_data[1], rec_last[1], done_at, exp_beat(1, 0));
        end
    endtask

    initial begin
        rst = 1'b1;
        step(); step();
        test_reset();
        rst = 1'b0;
        step();
        test_wrap();
        test_saturate();
        test_back_pressure();
        test_join_stall();
        test_index_wrap();
        test_zero_len();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vv_add_stream_core.md
# vv_add_stream_core

Parametrised streaming element-wise vector adder for the vv_add datapath. It takes two operand streams of LANES packed elements per beat, adds lane by lane in wrap or unsigned-saturate mode, and emits a registered result stream. Alongside each result beat it emits the beat index, a one-hot bank select decoded from that index, and a last flag. It sits between the operand fetch units and the result buffer. It generalises the fixed 4-bit add, equality and decode primitives into a sequenced, back-pressured engine.

## Interface
- DW, 32, element width in bits
- LANES, 4, elements per beat
- LEN_W, 7, width of the vector length and beat index; the maximum length is 2^LEN_W - 1 beats
- SEL_W, 4, number of low index bits decoded to the one-hot bank select (output width 2^SEL_W); SEL_W <= LEN_W

- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle command strobe; accepted only in IDLE
- len  in  LEN_W  number of beats; sampled when start is accepted
- sat  in  1  mode: 1 = unsigned saturate, 0 = modulo 2^DW; sampled when start is accepted
- a_vld / a_rdy  in / out  1  operand A handshake
- a_data  in  LANES*DW  operand A; lane i is bits [i*DW +: DW]
- b_vld / b_rdy  in / out  1  operand B handshake
- b_data  in  LANES*DW  operand B
- o_vld / o_rdy  out / in  1  result handshake
- o_data  out  LANES*DW  result lanes
- o_idx  out  LEN_W  beat index, starting at 0
- o_sel  out  2^SEL_W  one-hot decode of o_idx[SEL_W-1:0]
- o_last  out  1  set on the final beat
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN: start=1 and len!=0. len and sat are latched, and the beat counter is cleared.
- IDLE to DONE: start=1 and len==0. No beats are produced.
- start is ignored in every state other than IDLE.
- Join rule: a_rdy = b_rdy = (state==RUN) & a_vld & b_vld & (~o_vld | o_rdy). Both operands are consumed together or not at all. A single valid operand is never consumed.
- On each accept:
  - o_data lane i is computed as follows. With sat=0: (a_i + b_i) mod 2^DW. With sat=1: the carry-out of a lane forces that lane to 2^DW - 1.
  - o_idx = cnt; o_sel = 1 << cnt[SEL_W-1:0].
  - o_last = (cnt == len_q - 1); cnt increments.
- The accept with o_last=1 moves RUN to DRAIN.
- DRAIN to DONE: the output register handshakes while o_last=1.
- DONE: done=1 for exactly one cycle, then IDLE.
- An output beat stays stable while o_vld=1 and o_rdy=0. No field may change until it is accepted.
- The counter does not wrap within one command, because len <= 2^LEN_W - 1. o_sel does wrap every 2^SEL_W beats.

## Timing
- Reset values: o_vld=0, o_data=0, o_idx=0, o_sel=0, o_last=0, a_rdy=b_rdy=0, busy=0, done=0. State = IDLE, cnt=0, len_q=0, sat_q=0.
- Reset takes effect on the next edge from any state. An in-flight beat is discarded and no done pulse is issued.
- Start accepted at edge T: busy=1 from T+1, and the first possible input accept is at T+1.
- Latency: an input accepted at edge k gives o_vld=1 after edge k. This is a single register stage.
- Throughput: one beat per cycle when a_vld, b_vld and o_rdy are held high.
- Completion: the last output is accepted at edge m. state=DONE and done=1 after edge m. IDLE, busy=0 and done=0 after edge m+1.
- A zero-length command accepted at T gives done=1 after T+1.
- In the cycle where o_rdy=1 pops the held beat, a new accept may load the register in the same cycle.

## Test plan
- Wrap add. DW=32, LANES=4, len=3, sat=0, all valid/ready held high.
  - Beat 0: lane0 has a=0xFFFF_FFFF, b=2; expect lane0 = 0x0000_0001.
  - Expect o_idx 0,1,2 on consecutive cycles, o_last only on idx 2, then one done pulse.
- Saturate. Same operands with sat=1.
  - Expect lane0 = 0xFFFF_FFFF.
  - A non-overflowing lane, 5+7, gives 12.
- Back-pressure. len=4; hold o_rdy=0 for 3 cycles on beat 1.
  - o_data, o_idx=1 and o_sel=0x0002 stay stable.
  - a_rdy and b_rdy stay 0.
  - No beat is lost or duplicated.
- Join stall. a_vld=1, b_vld=0 for 5 cycles.
  - No accept and no o_vld.
  - When b_vld rises, a single beat is consumed from both streams.
- Index decode wrap. len=20, SEL_W=4.
  - o_sel for idx 15 is 0x8000; for idx 16 it is 0x0001.
  - o_last on idx 19.
  - start pulsed mid-run is ignored.
- Edge cases:
  - len=0: done pulses 2 cycles after start and o_vld never rises.
  - rst asserted mid-RUN: the next cycle shows all outputs at their reset values and no done pulse.
  - A fresh start afterwards runs correctly.
